// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator.
//   - FSM state encodings (IDLE / RUN / STOP)
//   - calc_total : sum of active + porches + sync width (HTOT / VTOT)
//   - count_fits : true when total-1 is representable in a counter of 'width' bits
package video_timing_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    function automatic int calc_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic bit count_fits(input int total, input int width);
        if (total < 1 || width < 1 || width > 31) begin
            return 1'b0;
        end
        return (longint'(total) - 1) < (longint'(1) << width);
    endfunction

endpackage

// File: rtl/sync_window.sv
// Combinational sync window decode.
//   i_cnt  : counter value (width bits)
//   o_sync : 'pol' while lo <= i_cnt < lo+len, otherwise ~pol
module sync_window #(
    parameter int lo    = 0,
    parameter int len   = 1,
    parameter int width = 8,
    parameter bit pol   = 1'b1
) (
    input  logic [width-1:0] i_cnt,
    output logic             o_sync
);

    // One extra bit so lo+len (which may equal the counter period) compares cleanly.
    localparam logic [width:0] c_lo = (width+1)'(lo);
    localparam logic [width:0] c_hi = (width+1)'(lo + len);

    logic [width:0] cnt_ext;
    logic           in_win;

    assign cnt_ext = {1'b0, i_cnt};
    assign in_win  = (cnt_ext >= c_lo) && (cnt_ext < c_hi);
    assign o_sync  = in_win ? pol : ~pol;

endmodule

// File: rtl/hv_timing_gen.sv
// Raster video timing generator.
//   i_clk / i_rst : pixel clock, asynchronous active-high reset
//   i_en          : run request; output starts/stops only on frame boundaries
//   o1_hcnt/vcnt  : position, 0 = first active pixel / line
//   o1_de         : data enable
//   o1_hsync/vsync: syncs at the configured polarities
//   o1_hclr       : pulse at each line start
//   o1_fs         : pulse at each frame start
//   o1_busy       : high while a frame is being produced (RUN or STOP)
// All outputs are registered; decodes use next-state counters so they line up
// with the registered counter outputs.
module hv_timing_gen
    import video_timing_pkg::*;
#(
    parameter int p_hcnt = 11,
    parameter int p_vcnt = 11,
    parameter int p_hact = 1280,
    parameter int p_hfp  = 110,
    parameter int p_hsw  = 40,
    parameter int p_hbp  = 220,
    parameter int p_vact = 720,
    parameter int p_vfp  = 5,
    parameter int p_vsw  = 5,
    parameter int p_vbp  = 20,
    parameter int p_hpol = 1,
    parameter int p_vpol = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic [p_hcnt-1:0] o1_hcnt,
    output logic [p_vcnt-1:0] o1_vcnt,
    output logic              o1_de,
    output logic              o1_hsync,
    output logic              o1_vsync,
    output logic              o1_hclr,
    output logic              o1_fs,
    output logic              o1_busy
);

    localparam int c_htot = calc_total(p_hact, p_hfp, p_hsw, p_hbp);
    localparam int c_vtot = calc_total(p_vact, p_vfp, p_vsw, p_vbp);

    generate
        if (!count_fits(c_htot, p_hcnt)) begin : g_hcnt_too_narrow
            $error("hv_timing_gen: HTOT-1 does not fit in p_hcnt bits");
        end
        if (!count_fits(c_vtot, p_vcnt)) begin : g_vcnt_too_narrow
            $error("hv_timing_gen: VTOT-1 does not fit in p_vcnt bits");
        end
    endgenerate

    localparam logic [p_hcnt-1:0] c_hlast = p_hcnt'(c_htot - 1);
    localparam logic [p_vcnt-1:0] c_vlast = p_vcnt'(c_vtot - 1);
    localparam logic [p_hcnt:0]   c_hact  = (p_hcnt+1)'(p_hact);
    localparam logic [p_vcnt:0]   c_vact  = (p_vcnt+1)'(p_vact);
    localparam bit                c_hpol  = (p_hpol != 0);
    localparam bit                c_vpol  = (p_vpol != 0);

    logic [1:0]        state_q, state_d;
    logic [p_hcnt-1:0] hcnt_q, hcnt_d;
    logic [p_vcnt-1:0] vcnt_q, vcnt_d;
    logic              de_q, de_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              hclr_q, hclr_d;
    logic              fs_q, fs_d;
    logic              busy_q, busy_d;

    logic last_h, last_v, active_d;
    logic hsync_win, vsync_win;

    // State and counter advance.
    always_comb begin
        state_d = state_q;
        hcnt_d  = '0;
        vcnt_d  = '0;
        last_h  = (hcnt_q == c_hlast);
        last_v  = (vcnt_q == c_vlast);
        case (state_q)
            ST_RUN, ST_STOP: begin
                // A frame in progress always completes; only the last pixel
                // decides between the next frame and IDLE.
                if (last_h && last_v) begin
                    state_d = i_en ? ST_RUN : ST_IDLE;
                end else begin
                    state_d = i_en ? ST_RUN : ST_STOP;
                end
                if (last_h) begin
                    hcnt_d = '0;
                    vcnt_d = last_v ? '0 : vcnt_q + 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                    vcnt_d = vcnt_q;
                end
            end
            default: begin
                state_d = i_en ? ST_RUN : ST_IDLE;
            end
        endcase
    end

    sync_window #(
        .lo   (p_hact + p_hfp),
        .len  (p_hsw),
        .width(p_hcnt),
        .pol  (c_hpol)
    ) u_hsync_win (
        .i_cnt (hcnt_d),
        .o_sync(hsync_win)
    );

    // vcnt only moves when hcnt wraps, so vsync edges land on hcnt = 0.
    sync_window #(
        .lo   (p_vact + p_vfp),
        .len  (p_vsw),
        .width(p_vcnt),
        .pol  (c_vpol)
    ) u_vsync_win (
        .i_cnt (vcnt_d),
        .o_sync(vsync_win)
    );

    // Output decodes on the next-state counters.
    always_comb begin
        active_d = (state_d != ST_IDLE);
        de_d     = active_d && ({1'b0, hcnt_d} < c_hact) && ({1'b0, vcnt_d} < c_vact);
        hsync_d  = active_d ? hsync_win : ~c_hpol;
        vsync_d  = active_d ? vsync_win : ~c_vpol;
        hclr_d   = active_d && (hcnt_d == '0);
        fs_d     = hclr_d && (vcnt_d == '0);
        busy_d   = active_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~c_hpol;
            vsync_q <= ~c_vpol;
            hclr_q  <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hclr_q  <= hclr_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign o1_hcnt  = hcnt_q;
    assign o1_vcnt  = vcnt_q;
    assign o1_de    = de_q;
    assign o1_hsync = hsync_q;
    assign o1_vsync = vsync_q;
    assign o1_hclr  = hclr_q;
    assign o1_fs    = fs_q;
    assign o1_busy  = busy_q;

endmodule
